jtag_tap_param: RTL and testbench
=================================

Name: jtag_tap_param

Overview:
- Parametrised JTAG test access port: full IEEE 1149.1 16-state TAP FSM, IR_WIDTH instruction register, IDCODE, BYPASS, a BSR_LEN-cell boundary-scan register and a UDR_WIDTH user data register.
- Sits between the J20 JTAG header pins and the board I/O/core-logic wrappers; next-generation replacement for the fixed 4-bit/10-cell TAP top.
- Adds synchronous board reset, capture/update on arbitrary widths, and unknown-opcode-to-BYPASS decoding.

Parameters:
IR_WIDTH, 4, instruction register width (>=4); opcodes below are zero-extended, BYPASS is all-ones
BSR_LEN, 10, boundary-scan cell count (>=1)
UDR_WIDTH, 8, user data register width (>=1)
IDCODE_VAL, 32'h0000_1093, IDCODE register contents; bit 0 must be 1

Ports:
TCK  in  1  test clock, sole clock, all logic on posedge
RST  in  1  synchronous active-high reset
TMS  in  1  test mode select
TDI  in  1  test data in
TDO  out  1  test data out (combinational mux of selected shift-register LSB)
TDO_EN  out  1  high while state is SHIFT-DR or SHIFT-IR
state  out  4  current TAP state encoding
IR_LATCH  out  IR_WIDTH  current active instruction
BSR_IN  in  BSR_LEN  parallel capture values (pins + core)
BSR_UPD  out  BSR_LEN  update latch of boundary-scan register
UDR_OUT  out  UDR_WIDTH  update latch of user data register
EXTEST_ACTIVE  out  1  IR_LATCH decodes EXTEST
INTEST_ACTIVE  out  1  IR_LATCH decodes INTEST

Behaviour:
- Clock/reset: one clock, TCK; reset RST is synchronous and active-high.
- State encoding: TLR=F, RTI=C, SELDR=7, CAPDR=6, SHDR=2, EX1DR=1, PSDR=3, EX2DR=0, UPDR=5, SELIR=4, CAPIR=E, SHIR=A, EX1IR=9, PSIR=B, EX2IR=8, UPIR=D.
- FSM: standard 1149.1 transitions on TMS at each posedge. Five consecutive TMS=1 edges reach TLR from any state.
- RST (sampled at posedge), values after the edge: state=TLR, IR_LATCH=IDCODE, all shift registers=0, BSR_UPD=0, UDR_OUT=0. RST overrides TMS and any in-progress shift.
- TLR state: IR_LATCH forced to IDCODE each edge. BSR_UPD and UDR_OUT retained; only RST clears them.
- Opcodes: IDCODE=7, SAMPLE=1, EXTEST=2, INTEST=3, USERCODE=8, BYPASS=all-ones. Any other value selects BYPASS.
- Register selection by IR_LATCH:
  - IDCODE: 32-bit ID register.
  - SAMPLE, EXTEST, INTEST: BSR.
  - USERCODE: UDR.
  - BYPASS and unknown opcodes: 1-bit bypass.
- Actions occur at the posedge taken while in the named state:
  - CAPIR: IR shift <= {0..0, 2'b01}.
  - SHIR: IR shift <= {TDI, ir[IR_WIDTH-1:1]}.
  - UPIR: IR_LATCH <= IR shift.
  - CAPDR, per selected register: ID <= IDCODE_VAL; BSR <= BSR_IN; UDR <= UDR_OUT (readback); bypass <= 0.
  - SHDR: selected register shifts right, TDI into MSB; unselected registers hold.
  - UPDR: if SAMPLE/EXTEST/INTEST, BSR_UPD <= BSR shift. If USERCODE, UDR_OUT <= UDR shift. Otherwise no update.
  - PSDR, PSIR, EX1*, EX2*: all registers hold.
- TDO: in SHIR, ir[0]; in SHDR, LSB of selected register; otherwise 0. TDO_EN tracks the same condition.
- Latency:
  - New IR_LATCH is visible the cycle after UPIR.
  - The first TDO bit after CAPDR is bit 0 of the captured value.
  - Bypass path delays TDI by exactly 1 TCK.
- EXTEST_ACTIVE and INTEST_ACTIVE are pure decodes of IR_LATCH. Both are low after RST.

Optional Feature:
JTAG_CLAMP_EN:
- Defined: adds opcode CLAMP=4 (zero-extended). CLAMP selects the bypass register and asserts EXTEST_ACTIVE, so pins are held from BSR_UPD while data shifts through 1 bit. UPDR does not modify BSR_UPD under CLAMP.
- Undefined: 4 is an unknown opcode and decodes to BYPASS with EXTEST_ACTIVE low.

Test Plan:
- RST 1 cycle, then TMS 0,1,0,0 to SHDR, shift 32 -> TDO yields 32'h0000_1093 LSB-first; IR_LATCH=7.
- Load IR=4'hF, shift DR pattern 1,0,1,1 with prior 0 captured -> TDO = 0,1,0,1 (one-cycle delay); unknown opcode 4'h5 gives identical behaviour.
- In SHIR with IR_WIDTH=4 -> first two TDO bits are 1,0 (captured 01).
- IR=SAMPLE, BSR_IN=10'h2A5: CAPDR then shift 10'h155 -> TDO reads 10'h2A5; after UPDR, BSR_UPD=10'h155.
- IR=USERCODE: shift 8'hC3, update -> UDR_OUT=8'hC3; next CAPDR/shift reads back 8'hC3.
- Assert RST mid-SHDR of EXTEST -> next cycle state=F, BSR_UPD=0, EXTEST_ACTIVE=0.
- From each of 16 states, five TMS=1 edges -> state=F and IR_LATCH=7.

Source files
------------

// File: rtl/jtag_tap_param_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_param_if
// Brief    : JTAG header pins and board-side parallel buses for the
//            parametrised TAP (TCK/RST are plain ports on the TAP itself).
// Revision : 1.0 - initial release
// ============================================================================
interface jtag_tap_param_if #(
    parameter int IR_WIDTH  = 4,
    parameter int BSR_LEN   = 10,
    parameter int UDR_WIDTH = 8
);
    logic                 TMS;
    logic                 TDI;
    logic                 TDO;
    logic                 TDO_EN;
    logic [3:0]           state;
    logic [IR_WIDTH-1:0]  IR_LATCH;
    logic [BSR_LEN-1:0]   BSR_IN;
    logic [BSR_LEN-1:0]   BSR_UPD;
    logic [UDR_WIDTH-1:0] UDR_OUT;
    logic                 EXTEST_ACTIVE;
    logic                 INTEST_ACTIVE;

    // Header/board side that drives the TAP
    modport master (
        output TMS, TDI, BSR_IN,
        input  TDO, TDO_EN, state, IR_LATCH, BSR_UPD, UDR_OUT,
               EXTEST_ACTIVE, INTEST_ACTIVE
    );

    // The TAP controller itself
    modport slave (
        input  TMS, TDI, BSR_IN,
        output TDO, TDO_EN, state, IR_LATCH, BSR_UPD, UDR_OUT,
               EXTEST_ACTIVE, INTEST_ACTIVE
    );
endinterface
`default_nettype wire

// File: rtl/jtag_tap_param.sv
`default_nettype none
// ============================================================================
// Module   : jtag_tap_param
// Brief    : Parametrised IEEE 1149.1 TAP: 16-state FSM, IR, IDCODE, BYPASS,
//            boundary-scan register and user data register.
//            Optional macro JTAG_CLAMP_EN adds the CLAMP instruction (opcode 4).
// Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_param #(
    parameter int          IR_WIDTH   = 4,
    parameter int          BSR_LEN    = 10,
    parameter int          UDR_WIDTH  = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h0000_1093
) (
    input  wire logic        TCK,
    input  wire logic        RST,
    jtag_tap_param_if.slave  bus
);
    // TAP state encoding (standard 1149.1 codes)
    localparam logic [3:0] c_TLR   = 4'hF;
    localparam logic [3:0] c_RTI   = 4'hC;
    localparam logic [3:0] c_SELDR = 4'h7;
    localparam logic [3:0] c_CAPDR = 4'h6;
    localparam logic [3:0] c_SHDR  = 4'h2;
    localparam logic [3:0] c_EX1DR = 4'h1;
    localparam logic [3:0] c_PSDR  = 4'h3;
    localparam logic [3:0] c_EX2DR = 4'h0;
    localparam logic [3:0] c_UPDR  = 4'h5;
    localparam logic [3:0] c_SELIR = 4'h4;
    localparam logic [3:0] c_CAPIR = 4'hE;
    localparam logic [3:0] c_SHIR  = 4'hA;
    localparam logic [3:0] c_EX1IR = 4'h9;
    localparam logic [3:0] c_PSIR  = 4'hB;
    localparam logic [3:0] c_EX2IR = 4'h8;
    localparam logic [3:0] c_UPIR  = 4'hD;

    // Opcodes, zero-extended to the IR width; all-ones (BYPASS) falls to default
    localparam logic [IR_WIDTH-1:0] c_OP_IDCODE   = IR_WIDTH'(7);
    localparam logic [IR_WIDTH-1:0] c_OP_SAMPLE   = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] c_OP_EXTEST   = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] c_OP_INTEST   = IR_WIDTH'(3);
    localparam logic [IR_WIDTH-1:0] c_OP_USERCODE = IR_WIDTH'(8);
`ifdef JTAG_CLAMP_EN
    localparam logic [IR_WIDTH-1:0] c_OP_CLAMP    = IR_WIDTH'(4);
`endif
    localparam logic [IR_WIDTH-1:0] c_IR_CAPTURE  = IR_WIDTH'(2'b01);

    logic [3:0]           r_state;
    logic [3:0]           w_next_state;
    logic [IR_WIDTH-1:0]  r_ir_shift;
    logic [IR_WIDTH-1:0]  r_ir_latch;
    logic [31:0]          r_id_shift;
    logic [BSR_LEN-1:0]   r_bsr_shift;
    logic [BSR_LEN-1:0]   r_bsr_upd;
    logic [UDR_WIDTH-1:0] r_udr_shift;
    logic [UDR_WIDTH-1:0] r_udr_out;
    logic                 r_bypass;
    logic                 w_sel_id, w_sel_bsr, w_sel_udr, w_sel_byp;
    logic                 w_extest, w_intest;
    logic                 w_tdo, w_tdo_en;

    // State register: RST forces Test-Logic-Reset regardless of TMS
    always_ff @(posedge TCK) begin
        if (RST) r_state <= c_TLR;
        else     r_state <= w_next_state;
    end

    // Next-state logic: standard 1149.1 transitions on TMS
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_TLR:   w_next_state = bus.TMS ? c_TLR   : c_RTI;
            c_RTI:   w_next_state = bus.TMS ? c_SELDR : c_RTI;
            c_SELDR: w_next_state = bus.TMS ? c_SELIR : c_CAPDR;
            c_CAPDR: w_next_state = bus.TMS ? c_EX1DR : c_SHDR;
            c_SHDR:  w_next_state = bus.TMS ? c_EX1DR : c_SHDR;
            c_EX1DR: w_next_state = bus.TMS ? c_UPDR  : c_PSDR;
            c_PSDR:  w_next_state = bus.TMS ? c_EX2DR : c_PSDR;
            c_EX2DR: w_next_state = bus.TMS ? c_UPDR  : c_SHDR;
            c_UPDR:  w_next_state = bus.TMS ? c_SELDR : c_RTI;
            c_SELIR: w_next_state = bus.TMS ? c_TLR   : c_CAPIR;
            c_CAPIR: w_next_state = bus.TMS ? c_EX1IR : c_SHIR;
            c_SHIR:  w_next_state = bus.TMS ? c_EX1IR : c_SHIR;
            c_EX1IR: w_next_state = bus.TMS ? c_UPIR  : c_PSIR;
            c_PSIR:  w_next_state = bus.TMS ? c_EX2IR : c_PSIR;
            c_EX2IR: w_next_state = bus.TMS ? c_UPIR  : c_SHIR;
            c_UPIR:  w_next_state = bus.TMS ? c_SELDR : c_RTI;
            default: w_next_state = c_TLR;
        endcase
    end

    // Instruction decode: selects the data register and the test-mode flags
    always_comb begin
        w_sel_id  = 1'b0;
        w_sel_bsr = 1'b0;
        w_sel_udr = 1'b0;
        w_sel_byp = 1'b0;
        w_extest  = 1'b0;
        w_intest  = 1'b0;
        case (r_ir_latch)
            c_OP_IDCODE:   w_sel_id  = 1'b1;
            c_OP_SAMPLE:   w_sel_bsr = 1'b1;
            c_OP_EXTEST:   begin w_sel_bsr = 1'b1; w_extest = 1'b1; end
            c_OP_INTEST:   begin w_sel_bsr = 1'b1; w_intest = 1'b1; end
            c_OP_USERCODE: w_sel_udr = 1'b1;
`ifdef JTAG_CLAMP_EN
            // Pins stay driven from BSR_UPD while only the bypass bit shifts
            c_OP_CLAMP:    begin w_sel_byp = 1'b1; w_extest = 1'b1; end
`endif
            default:       w_sel_byp = 1'b1;
        endcase
    end

    // Output logic: TDO mux of the active shift register LSB
    always_comb begin
        w_tdo    = 1'b0;
        w_tdo_en = 1'b0;
        if (r_state == c_SHIR) begin
            w_tdo    = r_ir_shift[0];
            w_tdo_en = 1'b1;
        end else if (r_state == c_SHDR) begin
            w_tdo_en = 1'b1;
            if (w_sel_id)       w_tdo = r_id_shift[0];
            else if (w_sel_bsr) w_tdo = r_bsr_shift[0];
            else if (w_sel_udr) w_tdo = r_udr_shift[0];
            else                w_tdo = r_bypass;
        end
    end

    // Datapath: capture/shift/update actions keyed on the current TAP state
    always_ff @(posedge TCK) begin
        if (RST) begin
            r_ir_shift  <= '0;
            r_ir_latch  <= c_OP_IDCODE;
            r_id_shift  <= '0;
            r_bsr_shift <= '0;
            r_bsr_upd   <= '0;
            r_udr_shift <= '0;
            r_udr_out   <= '0;
            r_bypass    <= 1'b0;
        end else begin
            case (r_state)
                c_CAPIR: r_ir_shift <= c_IR_CAPTURE;
                c_SHIR:  r_ir_shift <= {bus.TDI, r_ir_shift[IR_WIDTH-1:1]};
                c_UPIR:  r_ir_latch <= r_ir_shift;
                c_CAPDR: begin
                    if (w_sel_id)  r_id_shift  <= IDCODE_VAL;
                    if (w_sel_bsr) r_bsr_shift <= bus.BSR_IN;
                    if (w_sel_udr) r_udr_shift <= r_udr_out;
                    if (w_sel_byp) r_bypass    <= 1'b0;
                end
                c_SHDR: begin
                    // Concatenate-then-shift keeps single-bit widths legal
                    if (w_sel_id)  r_id_shift  <= {bus.TDI, r_id_shift[31:1]};
                    if (w_sel_bsr) r_bsr_shift <= BSR_LEN'({bus.TDI, r_bsr_shift} >> 1);
                    if (w_sel_udr) r_udr_shift <= UDR_WIDTH'({bus.TDI, r_udr_shift} >> 1);
                    if (w_sel_byp) r_bypass    <= bus.TDI;
                end
                c_UPDR: begin
                    if (w_sel_bsr) r_bsr_upd <= r_bsr_shift;
                    if (w_sel_udr) r_udr_out <= r_udr_shift;
                end
                c_TLR:   r_ir_latch <= c_OP_IDCODE;
                default: ;
            endcase
            // Entering TLR resets the instruction so IDCODE is active on arrival
            if (w_next_state == c_TLR) r_ir_latch <= c_OP_IDCODE;
        end
    end

    assign bus.TDO           = w_tdo;
    assign bus.TDO_EN        = w_tdo_en;
    assign bus.state         = r_state;
    assign bus.IR_LATCH      = r_ir_latch;
    assign bus.BSR_UPD       = r_bsr_upd;
    assign bus.UDR_OUT       = r_udr_out;
    assign bus.EXTEST_ACTIVE = w_extest;
    assign bus.INTEST_ACTIVE = w_intest;
endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_tap_param
// Brief    : Self-checking bench for jtag_tap_param: directed scan sequences
//            plus random TMS/TDI walks compared against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_param;
    localparam int          IRW  = 4;
    localparam int          BSRL = 10;
    localparam int          UDRW = 8;
    localparam logic [31:0] IDV  = 32'h0000_1093;

    logic TCK = 1'b0;
    logic RST = 1'b0;

    jtag_tap_param_if #(.IR_WIDTH(IRW), .BSR_LEN(BSRL), .UDR_WIDTH(UDRW)) bus();

    jtag_tap_param #(
        .IR_WIDTH(IRW), .BSR_LEN(BSRL), .UDR_WIDTH(UDRW), .IDCODE_VAL(IDV)
    ) dut (
        .TCK(TCK),
        .RST(RST),
        .bus(bus)
    );

    always #5 TCK = ~TCK;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: TAP transition table indexed by state code, TMS=0 / TMS=1
    int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    int              m_state;
    logic [IRW-1:0]  m_ir_sh, m_ir;
    logic [31:0]     m_id;
    logic [BSRL-1:0] m_bsr, m_bsr_upd;
    logic [UDRW-1:0] m_udr, m_udr_out;
    logic            m_byp;

    // Register selected by an instruction: 0=ID, 1=BSR, 2=UDR, 3=bypass
    function automatic int kind(input logic [IRW-1:0] ir);
        int v = int'(ir);
        if (v == 7) return 0;
        if (v == 1 || v == 2 || v == 3) return 1;
        if (v == 8) return 2;
        return 3;
    endfunction

    function automatic logic m_extest();
`ifdef JTAG_CLAMP_EN
        return (int'(m_ir) == 2) || (int'(m_ir) == 4);
`else
        return int'(m_ir) == 2;
`endif
    endfunction

    function automatic logic m_tdo();
        int k = kind(m_ir);
        if (m_state == 10) return m_ir_sh[0];
        if (m_state != 2) return 1'b0;
        case (k)
            0:       return m_id[0];
            1:       return m_bsr[0];
            2:       return m_udr[0];
            default: return m_byp;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic tms, input logic tdi,
                              input logic [BSRL-1:0] bin);
        int k;
        if (r) begin
            m_state = 15; m_ir = IRW'(7); m_ir_sh = '0; m_id = '0; m_bsr = '0;
            m_byp = 1'b0; m_udr = '0; m_bsr_upd = '0; m_udr_out = '0;
            return;
        end
        k = kind(m_ir);
        case (m_state)
            14: m_ir_sh = IRW'(1);
            10: m_ir_sh = (m_ir_sh >> 1) | (IRW'(tdi) << (IRW - 1));
            13: m_ir = m_ir_sh;
            6: begin
                if (k == 0) m_id  = IDV;
                if (k == 1) m_bsr = bin;
                if (k == 2) m_udr = m_udr_out;
                if (k == 3) m_byp = 1'b0;
            end
            2: begin
                if (k == 0) m_id  = (m_id >> 1)  | (32'(tdi) << 31);
                if (k == 1) m_bsr = (m_bsr >> 1) | (BSRL'(tdi) << (BSRL - 1));
                if (k == 2) m_udr = (m_udr >> 1) | (UDRW'(tdi) << (UDRW - 1));
                if (k == 3) m_byp = tdi;
            end
            5: begin
                if (k == 1) m_bsr_upd = m_bsr;
                if (k == 2) m_udr_out = m_udr;
            end
            15: m_ir = IRW'(7);
            default: ;
        endcase
        m_state = tms ? nxt1[m_state] : nxt0[m_state];
        if (m_state == 15) m_ir = IRW'(7);
    endtask

    task automatic check_outputs();
        chk("state",    64'(bus.state),         64'(m_state));
        chk("ir_latch", 64'(bus.IR_LATCH),      64'(m_ir));
        chk("bsr_upd",  64'(bus.BSR_UPD),       64'(m_bsr_upd));
        chk("udr_out",  64'(bus.UDR_OUT),       64'(m_udr_out));
        chk("tdo",      64'(bus.TDO),           64'(m_tdo()));
        chk("tdo_en",   64'(bus.TDO_EN),        64'(m_state == 10 || m_state == 2));
        chk("extest",   64'(bus.EXTEST_ACTIVE), 64'(m_extest()));
        chk("intest",   64'(bus.INTEST_ACTIVE), 64'(int'(m_ir) == 3));
    endtask

    // One TCK cycle: drive, check pre-edge outputs, advance model, take the edge
    task automatic cyc(input logic r, input logic tms, input logic tdi, output logic tdo_o);
        RST = r; bus.TMS = tms; bus.TDI = tdi;
        #2;
        check_outputs();
        tdo_o = bus.TDO;
        model_step(r, tms, tdi, bus.BSR_IN);
        @(posedge TCK);
        #1;
    endtask

    // From RTI: load an instruction, return the bits shifted out of the IR
    task automatic load_ir(input logic [IRW-1:0] op, output logic [IRW-1:0] cap);
        logic t;
        cyc(0, 1, 0, t); cyc(0, 1, 0, t); cyc(0, 0, 0, t); cyc(0, 0, 0, t);
        for (int i = 0; i < IRW; i++) begin
            cyc(0, (i == IRW - 1), op[i], t);
            cap[i] = t;
        end
        cyc(0, 1, 0, t); cyc(0, 0, 0, t);
    endtask

    // From RTI: capture, shift n bits LSB-first, update, back to RTI
    task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
        logic t;
        dout = '0;
        cyc(0, 1, 0, t); cyc(0, 0, 0, t); cyc(0, 0, 0, t);
        for (int i = 0; i < n; i++) begin
            cyc(0, (i == n - 1), din[i], t);
            dout[i] = t;
        end
        cyc(0, 1, 0, t); cyc(0, 0, 0, t);
    endtask

    initial begin
        logic           t;
        logic [IRW-1:0] cap;
        logic [63:0]    d;
        int             steps;

        RST = 1'b1; bus.TMS = 1'b0; bus.TDI = 1'b0; bus.BSR_IN = '0;
        @(posedge TCK); #1;
        model_step(1, 0, 0, '0);

        // Reset state
        chk("rst_state",  64'(bus.state), 64'hF);
        chk("rst_ir",     64'(bus.IR_LATCH), 64'h7);
        chk("rst_bsrupd", 64'(bus.BSR_UPD), 64'h0);
        chk("rst_udr",    64'(bus.UDR_OUT), 64'h0);
        chk("rst_extest", 64'(bus.EXTEST_ACTIVE), 64'h0);

        // IDCODE read out LSB-first
        cyc(0, 0, 0, t);
        shift_dr(32, 64'h0, d);
        chk("idcode_tdo", 64'(d[31:0]), 64'h0000_1093);
        chk("idcode_ir",  64'(bus.IR_LATCH), 64'h7);

        // BYPASS and an unknown opcode: one-cycle delay with captured 0 first
        load_ir(4'hF, cap);
        chk("ir_capture", 64'(cap[1:0]), 64'h1);
        shift_dr(4, 64'hD, d);
        chk("bypass_F", 64'(d[3:0]), 64'hA);
        load_ir(4'h5, cap);
        shift_dr(4, 64'hD, d);
        chk("bypass_5", 64'(d[3:0]), 64'hA);

        // SAMPLE: capture pins, shift a new pattern in, update
        bus.BSR_IN = 10'h2A5;
        load_ir(4'h1, cap);
        shift_dr(10, 64'h155, d);
        chk("sample_tdo", 64'(d[9:0]), 64'h2A5);
        chk("sample_upd", 64'(bus.BSR_UPD), 64'h155);

        // USERCODE: write then read back the user data register
        load_ir(4'h8, cap);
        shift_dr(8, 64'hC3, d);
        chk("udr_out", 64'(bus.UDR_OUT), 64'hC3);
        shift_dr(8, 64'h00, d);
        chk("udr_readback", 64'(d[7:0]), 64'hC3);

        // Reset in the middle of an EXTEST data shift
        load_ir(4'h2, cap);
        chk("extest_on", 64'(bus.EXTEST_ACTIVE), 64'h1);
        cyc(0, 1, 0, t); cyc(0, 0, 0, t); cyc(0, 0, 0, t);
        cyc(0, 0, 1, t); cyc(0, 0, 0, t); cyc(0, 0, 1, t);
        cyc(1, 0, 1, t);
        chk("midrst_state",  64'(bus.state), 64'hF);
        chk("midrst_bsrupd", 64'(bus.BSR_UPD), 64'h0);
        chk("midrst_extest", 64'(bus.EXTEST_ACTIVE), 64'h0);

        // Five TMS=1 edges reach TLR from every state
        for (int target = 0; target < 16; target++) begin
            steps = 0;
            while (m_state != target && steps < 400) begin
                bus.BSR_IN = BSRL'($urandom);
                cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
                steps++;
            end
            chk("reach_state", 64'(m_state), 64'(target));
            for (int i = 0; i < 5; i++) cyc(0, 1, 1'($urandom_range(0, 1)), t);
            chk("tlr5_state", 64'(bus.state), 64'hF);
            chk("tlr5_ir",    64'(bus.IR_LATCH), 64'h7);
        end

        // Random walk with occasional resets
        for (int i = 0; i < 3000; i++) begin
            bus.BSR_IN = BSRL'($urandom);
            cyc(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), t);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
